window_3x3_gen: RTL

Consumer end of the 3x3 convolution line-buffer stream. Accepts one 3-row pixel column per valid cycle (taps row0 = oldest row, row2 = newest row), assembles complete 3x3 windows in a column shift register, applies border zero-padding, and emits one registered window per output pixel in raster order of window centre. Sits between the line buffer and the convolution MAC array.

---
 rtl/window_3x3_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: assembles 3x3 windows from 3-row column taps with optional zero border.
// Define WINGEN_COORD_EN to add win_row/win_col centre coordinate outputs.
module window_3x3_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PADDING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_row0,
  input  logic [7:0]  in_row1,
  input  logic [7:0]  in_row2,
  input  logic        in_valid,
  output logic [71:0] win_data,
  output logic        win_valid,
`ifdef WINGEN_COORD_EN
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
`endif
  output logic        frame_done
);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] R_LAST = RW'(PADDING != 0 ? IMG_H : IMG_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [23:0] col1, col2, col_in;
  logic [71:0] win_nx;
  logic last, emit, done_nx;
`ifdef WINGEN_COORD_EN
  localparam int XR = $clog2(IMG_H);
  localparam int XC = $clog2(IMG_W);
  logic [XR-1:0] row_nx;
  logic [XC-1:0] col_nx;
`endif
  function automatic logic [71:0] pack(input logic [23:0] a, input logic [23:0] b, input logic [23:0] d);
    return {a[23:16], b[23:16], d[23:16], a[15:8], b[15:8], d[15:8], a[7:0], b[7:0], d[7:0]};
  endfunction
  assign last = (r == R_LAST) && (c == C_LAST);
  // rows outside the image are zeroed here so stored columns are already padded
  assign col_in = {(PADDING != 0 && r == RW'(1)) ? 8'd0 : in_row0, in_row1,
                   (PADDING != 0 && r == RW'(IMG_H)) ? 8'd0 : in_row2};
  always_comb begin
    state_nx = (state == RUN && in_valid && last && PADDING != 0) ? FLUSH : RUN;
    emit = 1'b0;
    done_nx = 1'b0;
    win_nx = pack(col1, col2, 24'd0);
`ifdef WINGEN_COORD_EN
    row_nx = XR'(IMG_H - 1);
    col_nx = XC'(IMG_W - 1);
`endif
    if (PADDING != 0) begin
      if (state == FLUSH) begin
        emit = 1'b1;
        done_nx = 1'b1;
      end else if (in_valid && r != '0 && c != '0) begin
        emit = 1'b1;
        win_nx = pack(c == CW'(1) ? 24'd0 : col1, col2, col_in);
`ifdef WINGEN_COORD_EN
        row_nx = XR'(r - RW'(1));
        col_nx = XC'(c - CW'(1));
`endif
      end else if (in_valid && r >= RW'(2) && c == '0) begin
        emit = 1'b1;
`ifdef WINGEN_COORD_EN
        row_nx = XR'(r - RW'(2));
`endif
      end
    end else if (in_valid && r >= RW'(2) && c >= CW'(2)) begin
      emit = 1'b1;
      done_nx = last;
      win_nx = pack(col1, col2, col_in);
`ifdef WINGEN_COORD_EN
      row_nx = XR'(r - RW'(1));
      col_nx = XC'(c - CW'(1));
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      r <= '0;
      c <= '0;
      col1 <= '0;
      col2 <= '0;
      win_data <= '0;
      win_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef WINGEN_COORD_EN
      win_row <= '0;
      win_col <= '0;
`endif
    end else begin
      state <= state_nx;
      win_valid <= emit;
      frame_done <= done_nx;
      if (emit) win_data <= win_nx;
`ifdef WINGEN_COORD_EN
      if (emit) win_row <= row_nx;
      if (emit) win_col <= col_nx;
`endif
      if (in_valid) begin
        col1 <= col2;
        col2 <= col_in;
        c <= (c == C_LAST) ? '0 : c + CW'(1);
        if (c == C_LAST) r <= (r == R_LAST) ? '0 : r + RW'(1);
      end
    end
endmodule
